// File: rtl/adder_seq_chunked_pkg.sv
// rtl/adder_seq_chunked_pkg.sv - shared state encoding and sizing helper for the chunked adder
package adder_seq_chunked_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational W-bit ripple-carry adder with carry into the top bit
module adder_chunk #(
  parameter int W = 4
) (
  input  logic         ci,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // Carry ripples through a loop variable so no vector feeds back on itself.
  always_comb begin
    logic c;
    s     = '0;
    c     = ci;
    c_msb = ci;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/adder_seq_chunked.sv
// rtl/adder_seq_chunked.sv - multi-cycle add/subtract reusing one CHUNK-bit adder, LSB chunk first
module adder_seq_chunked
  import adder_seq_chunked_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = idx_width(NCH);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             co_ch;
  logic             cm_ch;

  assign a_ch = a_r[int'(idx) * CHUNK +: CHUNK];
  assign b_ch = b_r[int'(idx) * CHUNK +: CHUNK];

  adder_chunk #(.W(CHUNK)) u_chunk (
    .ci    (carry),
    .a     (a_ch),
    .b     (b_ch),
    .s     (s_ch),
    .co    (co_ch),
    .c_msb (cm_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + ~borrow, so only B and the carry seed change.
            a_r      <= A;
            b_r      <= Sub ? ~B : B;
            carry    <= Sub ^ Cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          Sum[int'(idx) * CHUNK +: CHUNK] <= s_ch;
          carry <= co_ch;
          if (idx == IW'(NCH - 1)) begin
            Cout      <= co_ch;
            Ovf       <= cm_ch ^ co_ch;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low here, so the handshake edge can never also accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// tb/tb_adder_seq_chunked.sv - scoreboard bench over CHUNK=4, CHUNK=16 and CHUNK=1 instances
module tb_adder_seq_chunked;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         ir [3];
  logic         ov [3];
  logic         co [3];
  logic         of [3];
  logic [W-1:0] sm [3];

  res_t q0 [$];
  res_t q1 [$];
  res_t q2 [$];

  int passed = 0;
  int total = 0;
  int fails = 0;
  int nch [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  adder_seq_chunked #(.WIDTH(W), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .Sub(sub), .Cin(cin),
    .A(a), .B(b), .out_valid(ov[0]), .out_ready(out_ready), .Sum(sm[0]), .Cout(co[0]), .Ovf(of[0])
  );
  adder_seq_chunked #(.WIDTH(W), .CHUNK(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .Sub(sub), .Cin(cin),
    .A(a), .B(b), .out_valid(ov[1]), .out_ready(out_ready), .Sum(sm[1]), .Cout(co[1]), .Ovf(of[1])
  );
  adder_seq_chunked #(.WIDTH(W), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .Sub(sub), .Cin(cin),
    .A(a), .B(b), .out_valid(ov[2]), .out_ready(out_ready), .Sum(sm[2]), .Cout(co[2]), .Ovf(of[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    res_t r;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + (W+1)'(s ^ c);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return r;
  endfunction

  function automatic res_t pop(input int k);
    res_t r;
    r = '0;
    if (k == 0 && q0.size() > 0) r = q0.pop_front();
    if (k == 1 && q1.size() > 0) r = q1.pop_front();
    if (k == 2 && q2.size() > 0) r = q2.pop_front();
    return r;
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic c, input res_t exp);
    int n;
    n = 0;
    while (!(ir[0] && ir[1] && ir[2]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("accept_wait_timeout", 32'd0, 32'd1);
    a = x; b = y; sub = s; cin = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q0.push_back(exp);
    q1.push_back(exp);
    q2.push_back(exp);
  endtask

  task automatic finish_op(input bit check_lat, input string tag);
    int   lat [3];
    res_t exp;
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (ov[k] && lat[k] == 0) lat[k] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int k = 0; k < 3; k++) begin
      exp = pop(k);
      if (lat[k] == 0) begin
        chk($sformatf("%s_timeout_u%0d", tag, k), 32'd0, 32'd1);
      end else begin
        if (check_lat) chk($sformatf("%s_latency_u%0d", tag, k), lat[k], nch[k]);
        chk($sformatf("%s_result_u%0d", tag, k), {sm[k], co[k], of[k]}, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    res_t          hold;
    logic [W-1:0]  ra, rb;
    logic          rs, rc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_u%0d", k), {ir[k], ov[k], sm[k], co[k], of[k]}, {1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Wrap-around add with exact latency
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
    finish_op(1'b1, "add_wrap");

    // Signed overflow and carry-in
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
    finish_op(1'b1, "add_ovf");
    start_op(16'h1234, 16'h4321, 1'b0, 1'b1, '{16'h5556, 1'b0, 1'b0});
    finish_op(1'b1, "add_cin");

    // Subtract
    start_op(16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0});
    finish_op(1'b1, "sub_neg");
    start_op(16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1});
    finish_op(1'b1, "sub_ovf");
    start_op(16'h0010, 16'h0001, 1'b1, 1'b1, '{16'h000E, 1'b1, 1'b0});
    finish_op(1'b1, "sub_bin");

    // Back-pressure with stray in_valid during RUN and DONE
    start_op(16'h1357, 16'h2468, 1'b0, 1'b0, '{16'h37BF, 1'b0, 1'b0});
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 10 && !ov[0]; n++) begin
      chk("bp_run_in_ready", ir[0], 1'b0);
      @(posedge clk); #1;
    end
    chk("bp_done_reached", ov[0], 1'b1);
    hold = q0[0];
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", {sm[0], co[0], of[0]}, hold);
      chk("bp_hold_in_ready", ir[0], 1'b0);
    end
    in_valid = 1'b0;
    finish_op(1'b0, "bp");
    chk("bp_idle_after_handshake", {ir[0], ov[0]}, 2'b10);
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0});
    finish_op(1'b1, "bp_next");

    // Reset during the 2nd RUN cycle
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("abort_u%0d", k), {ir[k], ov[k], sm[k], co[k], of[k]}, {1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0});
    finish_op(1'b1, "post_reset");

    // Random vectors against the reference model, all three chunk widths in parallel
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      start_op(ra, rb, rs, rc, model(ra, rb, rs, rc));
      finish_op(1'b0, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_seq_chunked.md
Name: adder_seq_chunked

Overview:
Parametrised multi-cycle adder/subtractor, the successor to the team's fixed 4-bit ripple adder. A single CHUNK-bit ripple adder is reused over WIDTH/CHUNK cycles, least-significant chunk first. Carry is held in a register between cycles. The block has valid/ready handshakes on both input and output. It also supports subtract mode and signed-overflow detection. It is used wherever a wide add is needed and area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle (the inner adder width). Range 1..WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- Sub  in  1  0 = add, 1 = subtract. Sampled on accept.
- Cin  in  1  carry-in (add) or borrow-in (subtract). Sampled on accept.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Sum  out  WIDTH  result.
- Cout  out  1  carry-out (add) or NOT-borrow (subtract).
- Ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset is one clock with asynchronous active-low reset rst_n. Assertion immediately forces state IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0, chunk index=0, carry register=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No partial result is ever presented.
- NCH = WIDTH/CHUNK.
- State IDLE:
  - in_ready=1.
  - Accept occurs on an edge where in_valid && in_ready.
  - On accept, latch A and B' (B' = Sub ? ~B : B) and set carry = Sub ? ~Cin : Cin.
  - Set index=0, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle adds chunk[index] of A and B' plus carry, writes Sum chunk[index] and updates carry.
  - On index==NCH-1: Cout = final carry-out; Ovf = carry-into-MSB XOR carry-out; go to DONE. Otherwise index++.
- State DONE:
  - out_valid=1, in_ready=0.
  - Sum, Cout and Ovf are held stable until out_ready is sampled high. Then go to IDLE with out_valid=0.
  - No new accept occurs in the same cycle as the DONE->IDLE transition.
- Latency: out_valid is high in the cycle after the NCH-th RUN edge, i.e. NCH cycles after the accept edge.
  - WIDTH=16, CHUNK=4 gives 4 cycles.
  - CHUNK=WIDTH gives 1 cycle.
- Throughput: one operation per NCH+2 cycles at best.
- Arithmetic:
  - Add: {Cout, Sum} = A + B + Cin.
  - Subtract: Sum = A - B - Cin (mod 2^WIDTH); Cout=1 means no borrow.
  - Results are exact modulo 2^WIDTH for all inputs.
- Sum bits not yet written during RUN are don't-care; they are only observable when out_valid=1.
- in_valid while in_ready=0 is ignored. The producer must hold its data until accepted.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Helper function for the index width, clog2(NCH) with a minimum of 1.
- One sub-module, adder_chunk (parameter W):
  - Purely combinational ripple chain of full adders.
  - Ports: ci, a[W], b[W], s[W], co, c_msb (carry into bit W-1).
  - Instantiated once in the datapath.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
1. A=0xFFFF, B=0x0001, Sub=0, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0. out_valid rises exactly 4 cycles after the accept edge.
2. A=0x7FFF, B=0x0001, Sub=0, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1. Also A=0x1234, B=0x4321, Cin=1 -> Sum=0x5556, Cout=0, Ovf=0.
3. Subtract:
   - A=0x0005, B=0x0007, Sub=1, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0.
   - A=0x8000, B=0x0001, Sub=1, Cin=0 -> Sum=0x7FFF, Cout=1, Ovf=1.
   - A=0x0010, B=0x0001, Sub=1, Cin=1 -> Sum=0x000E, Cout=1.
4. Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> Sum, Cout and Ovf are stable, and in_ready stays 0 throughout. in_valid pulses during RUN/DONE are ignored, and the next accept occurs only after the out_ready handshake.
5. Reset: assert rst_n=0 during the 2nd RUN cycle -> all outputs are 0 and in_ready=1 immediately. After release, a fresh operation (0x00FF + 0x0F01) returns 0x1000 with no corruption from the aborted operation.
6. Parameter sweep: CHUNK=16 (1-cycle latency) and CHUNK=1 (16-cycle latency). Run 1000 random vectors per configuration against a reference model -> all Sum, Cout and Ovf values match.
